runahead_replay_queue: RTL and testbench
========================================

// Module: runahead_replay_queue
// PURPOSE
// - Consumer end of the runahead queue interface. Buffers instructions diverted by the operand validation stage
//   (dirty operand or dirty forward) together with their would-have-forwarded flags.
// - Holds them until the blocking load writes back, then replays them in order to the issue stage.
// - Sits between runahead operand validation (producer) and the issue mux (consumer).
// PARAMETERS
// - DEPTH      8   entries; power of two, >=2
// - INST_W     16  instruction width
// - AGE_LIMIT  64  cycles in COLLECT before forced replay; used only with RUNAHEAD_REPLAY_AGE_LIMIT_EN
// PORTS
// - clk                 in   1               clock; all state on posedge
// - async_rst           in   1               asynchronous, active-high reset
// - clk_en              in   1               state advances only when high
// - EnqueueValid        in   1               instruction presented by operand validation
// - EnqueueInstruction  in   INST_W          instruction to buffer
// - EnqueueAForwarded   in   1               operand A would have forwarded
// - EnqueueBForwarded   in   1               operand B would have forwarded
// - EnqueueReady        out  1               ~full; upstream must stall issue when low
// - ReplayRelease       in   1               pulse: blocking load has written back
// - Flush               in   1               pipeline flush (mispredict/exception)
// - ReplayValid         out  1               replayed instruction available
// - ReplayInstruction   out  INST_W          head instruction
// - ReplayAForwarded    out  1               head A flag
// - ReplayBForwarded    out  1               head B flag
// - ReplayReady         in   1               issue stage accepts head
// - RunaheadActive      out  1               state != IDLE
// - QueueCount          out  $clog2(DEPTH)+1 occupancy
// - Overflow            out  1               sticky: enqueue attempted while full
// - AgeTimeout          out  1               1-cycle pulse on forced replay
// BEHAVIOUR
// - Reset:
//   - Pointers, QueueCount, Overflow, AgeTimeout and the age counter reset to 0.
//   - State resets to IDLE; ReplayValid=0 and RunaheadActive=0.
// - Storage: circular buffer.
//   - Rd/wr pointers are $clog2(DEPTH)+1 bits; the MSB disambiguates full from empty; pointers wrap naturally.
//   - Entry = {AForwarded, BForwarded, Instruction}.
// - Enqueue: accepted when EnqueueValid && EnqueueReady && clk_en && !Flush.
//   - EnqueueReady depends on registered state only.
//   - When full, a same-cycle dequeue does NOT admit the enqueue.
//   - EnqueueValid while full drops the entry and sets Overflow until reset.
// - Dequeue: occurs when ReplayValid && ReplayReady && clk_en.
//   - ReplayValid = (state==REPLAY) && !empty.
//   - Head outputs come straight from the storage read; zero added latency.
//   - An entry is replayable the cycle after it is written.
// - Simultaneous enqueue and dequeue: QueueCount unchanged, both pointers advance.
// - FSM, evaluated only on clk_en:
//   - IDLE    -> COLLECT on accepted enqueue. ReplayRelease is ignored in IDLE.
//   - COLLECT -> REPLAY on ReplayRelease (or age timeout). Enqueues continue.
//   - REPLAY  -> IDLE when the queue becomes empty after a dequeue with no same-cycle enqueue.
//     - Enqueues during REPLAY are appended and replayed in order.
//     - ReplayRelease in REPLAY is ignored.
// - Flush has priority over all events except reset:
//   - Next cycle: pointers 0, count 0, state IDLE.
//   - A same-cycle enqueue or dequeue is discarded and not counted.
//   - Overflow is kept.
// - Reset asserted mid-replay: all queued contents are lost; no replay outputs until new enqueues.
// CONFIGURATION
// - RUNAHEAD_REPLAY_AGE_LIMIT_EN defined:
//   - The age counter increments each clk_en cycle in COLLECT and clears on leaving COLLECT.
//   - When it reaches AGE_LIMIT-1 without ReplayRelease: COLLECT->REPLAY, and AgeTimeout pulses for 1 cycle.
// - Not defined:
//   - No counter.
//   - AgeTimeout is tied 0.
//   - COLLECT is left only on ReplayRelease or Flush.
// TESTING
// - Enqueue 3 instrs (0x1111,0x2222,0x3333, A flags 1,0,1), hold ReplayRelease=0 for 10 cycles
//   -> ReplayValid=0, QueueCount=3, RunaheadActive=1.
// - Pulse ReplayRelease, ReplayReady=1
//   -> 0x1111,0x2222,0x3333 on consecutive cycles with flags 1,0,1, then state IDLE and QueueCount=0.
// - Fill 8 entries, keep EnqueueValid=1 with 0xDEAD
//   -> EnqueueReady=0, Overflow=1, 0xDEAD never replayed, QueueCount=8.
// - In REPLAY with ReplayReady toggling, enqueue 0x4444 mid-drain
//   -> order preserved and 0x4444 replayed last; no IDLE until empty.
// - Assert Flush with 5 entries, same-cycle enqueue
//   -> next cycle QueueCount=0, IDLE, nothing replayed.
// - With RUNAHEAD_REPLAY_AGE_LIMIT_EN, AGE_LIMIT=64, no release
//   -> AgeTimeout pulses 64 cycles after entering COLLECT, then replay starts.

Source files
------------

// File: rtl/runahead_replay_queue.sv
// Runahead replay queue: buffers diverted instructions until the blocking load returns, then replays them in order.
// Optional forced replay after AGE_LIMIT cycles in COLLECT is enabled by defining RUNAHEAD_REPLAY_AGE_LIMIT_EN.
module runahead_replay_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned INST_W    = 16,
  parameter int unsigned AGE_LIMIT = 64
) (
  input  logic                       clk,
  input  logic                       async_rst,
  input  logic                       clk_en,
  input  logic                       EnqueueValid,
  input  logic [INST_W-1:0]          EnqueueInstruction,
  input  logic                       EnqueueAForwarded,
  input  logic                       EnqueueBForwarded,
  output logic                       EnqueueReady,
  input  logic                       ReplayRelease,
  input  logic                       Flush,
  output logic                       ReplayValid,
  output logic [INST_W-1:0]          ReplayInstruction,
  output logic                       ReplayAForwarded,
  output logic                       ReplayBForwarded,
  input  logic                       ReplayReady,
  output logic                       RunaheadActive,
  output logic [$clog2(DEPTH):0]     QueueCount,
  output logic                       Overflow,
  output logic                       AgeTimeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = INST_W + 2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AGE_LIMIT < 2) begin : g_param_check
    $error("runahead_replay_queue: DEPTH must be a power of two >= 2 and AGE_LIMIT >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPLAY} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            age_timeout_q, age_timeout_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   head;
  logic            full, empty, enq, deq, age_fire;

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign EnqueueReady   = !full;
  assign ReplayValid    = (state_q == S_REPLAY) && !empty;
  assign RunaheadActive = (state_q != S_IDLE);
  assign QueueCount     = count_q;
  assign Overflow       = overflow_q;
  assign AgeTimeout     = age_timeout_q;

  // Flush discards any same-cycle transfer on either side.
  assign enq = clk_en && !Flush && EnqueueValid && !full;
  assign deq = clk_en && !Flush && ReplayValid && ReplayReady;

  assign head              = mem_q[rd_ptr_q[AW-1:0]];
  assign ReplayInstruction = head[INST_W-1:0];
  assign ReplayAForwarded  = head[EW-1];
  assign ReplayBForwarded  = head[EW-2];

`ifdef RUNAHEAD_REPLAY_AGE_LIMIT_EN
  localparam int unsigned GW = $clog2(AGE_LIMIT);

  logic [GW-1:0] age_q, age_d;

  assign age_fire = (state_q == S_COLLECT) && !ReplayRelease && (age_q == GW'(AGE_LIMIT - 1));

  // Age counts clk_en cycles spent in COLLECT and clears whenever COLLECT is left.
  always_comb begin
    age_d = age_q;
    if (clk_en) begin
      if (Flush || state_q != S_COLLECT || ReplayRelease || age_fire) begin
        age_d = '0;
      end else begin
        age_d = age_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) age_q <= '0;
    else           age_q <= age_d;
  end
`else
  assign age_fire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    age_timeout_d = 1'b0;
    if (clk_en) begin
      if (Flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        state_d  = S_IDLE;
      end else begin
        if (EnqueueValid && full) overflow_d = 1'b1;
        if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
        if (enq && !deq)      count_d = count_q + PW'(1);
        else if (deq && !enq) count_d = count_q - PW'(1);
        case (state_q)
          S_IDLE: begin
            if (enq) state_d = S_COLLECT;
          end
          S_COLLECT: begin
            if (ReplayRelease || age_fire) begin
              state_d       = S_REPLAY;
              age_timeout_d = age_fire;
            end
          end
          S_REPLAY: begin
            if (deq && !enq && count_q == PW'(1)) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      age_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      age_timeout_q <= age_timeout_d;
    end
  end

  // Storage holds no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q[AW-1:0]] <= {EnqueueAForwarded, EnqueueBForwarded, EnqueueInstruction};
  end

endmodule

// File: tb/tb_runahead_replay_queue.sv
// Testbench for runahead_replay_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_runahead_replay_queue;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned INST_W    = 16;
  localparam int unsigned AGE_LIMIT = 64;
  localparam int unsigned CW        = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              async_rst, clk_en;
  logic              EnqueueValid, EnqueueAForwarded, EnqueueBForwarded, EnqueueReady;
  logic [INST_W-1:0] EnqueueInstruction, ReplayInstruction;
  logic              ReplayRelease, Flush, ReplayValid, ReplayAForwarded, ReplayBForwarded, ReplayReady;
  logic              RunaheadActive, Overflow, AgeTimeout;
  logic [CW-1:0]     QueueCount;

  runahead_replay_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .EnqueueValid(EnqueueValid), .EnqueueInstruction(EnqueueInstruction),
    .EnqueueAForwarded(EnqueueAForwarded), .EnqueueBForwarded(EnqueueBForwarded),
    .EnqueueReady(EnqueueReady), .ReplayRelease(ReplayRelease), .Flush(Flush),
    .ReplayValid(ReplayValid), .ReplayInstruction(ReplayInstruction),
    .ReplayAForwarded(ReplayAForwarded), .ReplayBForwarded(ReplayBForwarded),
    .ReplayReady(ReplayReady), .RunaheadActive(RunaheadActive), .QueueCount(QueueCount),
    .Overflow(Overflow), .AgeTimeout(AgeTimeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              a;
    logic              b;
    logic [INST_W-1:0] inst;
  } ent_t;

  int   checks = 0;
  int   failures = 0;
  ent_t mq[$];
  int   m_state;   // 0 idle, 1 collect, 2 replay
  bit   m_ovf, m_to;
  int   m_age;
  logic [INST_W-1:0] obs[$];

  // Model advances one clock from the current inputs.
  task automatic model_step();
    int n0;
    bit full, enq, deq, fire, to_n;
    to_n = 1'b0;
    fire = 1'b0;
    if (async_rst) begin
      mq.delete(); m_state = 0; m_ovf = 1'b0; m_age = 0; m_to = 1'b0;
      return;
    end
    if (clk_en) begin
      if (Flush) begin
        mq.delete(); m_state = 0; m_age = 0;
      end else begin
        n0   = mq.size();
        full = (n0 == DEPTH);
        enq  = EnqueueValid && !full;
        deq  = (m_state == 2) && (n0 > 0) && ReplayReady;
        if (EnqueueValid && full) m_ovf = 1'b1;
        if (deq) void'(mq.pop_front());
        if (enq) mq.push_back({EnqueueAForwarded, EnqueueBForwarded, EnqueueInstruction});
        case (m_state)
          0: if (enq) m_state = 1;
          1: begin
`ifdef RUNAHEAD_REPLAY_AGE_LIMIT_EN
            fire = !ReplayRelease && (m_age == AGE_LIMIT - 1);
`endif
            if (ReplayRelease || fire) begin
              m_state = 2; m_age = 0; to_n = fire;
            end else begin
              m_age++;
            end
          end
          default: if (deq && !enq && n0 == 1) m_state = 0;
        endcase
      end
    end
    m_to = to_n;
  endtask

  task automatic cycle();
    #2;
    if (!async_rst && clk_en && !Flush && ReplayValid && ReplayReady) obs.push_back(ReplayInstruction);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clk_en = 1'b1; EnqueueValid = 1'b0; EnqueueInstruction = '0;
    EnqueueAForwarded = 1'b0; EnqueueBForwarded = 1'b0;
    ReplayRelease = 1'b0; Flush = 1'b0; ReplayReady = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    async_rst = 1'b1;
    cycle(); cycle();
    async_rst = 1'b0;
    obs.delete();
  endtask

  task automatic push(input logic [INST_W-1:0] i, input logic a, input logic b);
    EnqueueValid = 1'b1; EnqueueInstruction = i; EnqueueAForwarded = a; EnqueueBForwarded = b;
    cycle();
    EnqueueValid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (QueueCount !== CW'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", QueueCount); end
    checks++; if (ReplayValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ReplayValid); end
    checks++; if (RunaheadActive !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", RunaheadActive); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", Overflow); end
    checks++; if (AgeTimeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", AgeTimeout); end
    checks++; if (EnqueueReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", EnqueueReady); end
  endtask

  task automatic test_collect_hold();
    do_reset();
    push(16'h1111, 1'b1, 1'b0);
    push(16'h2222, 1'b0, 1'b1);
    push(16'h3333, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++; if (ReplayValid !== 1'b0) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=0", k, ReplayValid); end
    end
    checks++; if (QueueCount !== CW'(3)) begin failures++; $display("FAIL hold_count got=%0d exp=3", QueueCount); end
    checks++; if (RunaheadActive !== 1'b1) begin failures++; $display("FAIL hold_active got=%b exp=1", RunaheadActive); end
  endtask

  task automatic test_release_drain();
    logic [INST_W-1:0] exp_i [3];
    logic              exp_a [3];
    logic              exp_b [3];
    exp_i = '{16'h1111, 16'h2222, 16'h3333};
    exp_a = '{1'b1, 1'b0, 1'b1};
    exp_b = '{1'b0, 1'b1, 1'b0};
    ReplayRelease = 1'b1; ReplayReady = 1'b1;
    cycle();
    ReplayRelease = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ReplayValid !== 1'b1) begin failures++; $display("FAIL drain_valid idx=%0d got=%b exp=1", i, ReplayValid); end
      checks++; if (ReplayInstruction !== exp_i[i]) begin failures++; $display("FAIL drain_inst idx=%0d got=%h exp=%h", i, ReplayInstruction, exp_i[i]); end
      checks++; if ({ReplayAForwarded, ReplayBForwarded} !== {exp_a[i], exp_b[i]}) begin
        failures++; $display("FAIL drain_flags idx=%0d got=%b%b exp=%b%b", i, ReplayAForwarded, ReplayBForwarded, exp_a[i], exp_b[i]);
      end
      cycle();
    end
    checks++; if (RunaheadActive !== 1'b0) begin failures++; $display("FAIL drain_idle got=%b exp=0", RunaheadActive); end
    checks++; if (QueueCount !== CW'(0)) begin failures++; $display("FAIL drain_count got=%0d exp=0", QueueCount); end
    checks++; if (ReplayValid !== 1'b0) begin failures++; $display("FAIL drain_valid_end got=%b exp=0", ReplayValid); end
  endtask

  task automatic test_overflow();
    logic [INST_W-1:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      e = 16'h0A00 + INST_W'(i);
      push(e, e[0], e[1]);
    end
    EnqueueValid = 1'b1; EnqueueInstruction = 16'hDEAD;
    repeat (3) cycle();
    checks++; if (EnqueueReady !== 1'b0) begin failures++; $display("FAIL ovf_ready got=%b exp=0", EnqueueReady); end
    checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", Overflow); end
    checks++; if (QueueCount !== CW'(8)) begin failures++; $display("FAIL ovf_count got=%0d exp=8", QueueCount); end
    EnqueueValid = 1'b0;
    ReplayRelease = 1'b1; cycle(); ReplayRelease = 1'b0;
    ReplayReady = 1'b1;
    for (int k = 0; k < 30 && RunaheadActive; k++) cycle();
    checks++; if (RunaheadActive !== 1'b0) begin failures++; $display("FAIL ovf_drain_timeout active=%b exp=0", RunaheadActive); end
    checks++; if (obs.size() != 8) begin failures++; $display("FAIL ovf_replay_count got=%0d exp=8", obs.size()); end
    for (int i = 0; i < obs.size() && i < 8; i++) begin
      e = 16'h0A00 + INST_W'(i);
      checks++; if (obs[i] !== e) begin failures++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, obs[i], e); end
    end
    checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", Overflow); end
  endtask

  task automatic test_replay_mid_enqueue();
    logic [INST_W-1:0] exp_q [5];
    exp_q = '{16'h5000, 16'h5001, 16'h5002, 16'h5003, 16'h4444};
    do_reset();
    for (int i = 0; i < 4; i++) push(16'h5000 + INST_W'(i), 1'b0, 1'b1);
    ReplayRelease = 1'b1; cycle(); ReplayRelease = 1'b0;
    for (int k = 0; k < 40 && obs.size() < 5; k++) begin
      ReplayReady = (k % 2 == 0);
      EnqueueValid = (k == 3); EnqueueInstruction = 16'h4444;
      cycle();
      EnqueueValid = 1'b0;
      checks++; if (RunaheadActive !== (obs.size() < 5)) begin
        failures++; $display("FAIL mid_active cyc=%0d got=%b exp=%b", k, RunaheadActive, obs.size() < 5);
      end
    end
    checks++; if (obs.size() != 5) begin failures++; $display("FAIL mid_replay_count got=%0d exp=5", obs.size()); end
    for (int i = 0; i < obs.size() && i < 5; i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL mid_order idx=%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) push(16'h6000 + INST_W'(i), 1'b1, 1'b1);
    Flush = 1'b1; EnqueueValid = 1'b1; EnqueueInstruction = 16'h7777;
    cycle();
    Flush = 1'b0; EnqueueValid = 1'b0;
    checks++; if (QueueCount !== CW'(0)) begin failures++; $display("FAIL flush_count got=%0d exp=0", QueueCount); end
    checks++; if (RunaheadActive !== 1'b0) begin failures++; $display("FAIL flush_idle got=%b exp=0", RunaheadActive); end
    ReplayRelease = 1'b1; ReplayReady = 1'b1; cycle(); ReplayRelease = 1'b0;
    repeat (3) cycle();
    checks++; if (obs.size() != 0) begin failures++; $display("FAIL flush_replayed got=%0d exp=0", obs.size()); end
    checks++; if (ReplayValid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", ReplayValid); end
  endtask

  task automatic test_reset_mid_replay();
    do_reset();
    for (int i = 0; i < 4; i++) push(16'h9000 + INST_W'(i), 1'b0, 1'b0);
    ReplayRelease = 1'b1; cycle(); ReplayRelease = 1'b0;
    ReplayReady = 1'b1; cycle();
    async_rst = 1'b1;
    #1;
    checks++; if (ReplayValid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", ReplayValid); end
    checks++; if (QueueCount !== CW'(0)) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", QueueCount); end
    cycle();
    async_rst = 1'b0;
    repeat (3) cycle();
    checks++; if (obs.size() != 1) begin failures++; $display("FAIL rst_mid_replayed got=%0d exp=1", obs.size()); end
    push(16'hABCD, 1'b1, 1'b0);
    ReplayRelease = 1'b1; cycle(); ReplayRelease = 1'b0;
    checks++; if (ReplayInstruction !== 16'hABCD) begin failures++; $display("FAIL rst_mid_new got=%h exp=abcd", ReplayInstruction); end
    ReplayReady = 1'b1; cycle();
  endtask

  task automatic test_random();
    bit exp_v;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      clk_en             = ($urandom_range(0, 9) != 0);
      EnqueueValid       = ($urandom_range(0, 2) != 0);
      EnqueueInstruction = INST_W'($urandom);
      EnqueueAForwarded  = 1'($urandom);
      EnqueueBForwarded  = 1'($urandom);
      ReplayRelease      = ($urandom_range(0, 15) == 0);
      Flush              = ($urandom_range(0, 40) == 0);
      ReplayReady        = 1'($urandom);
      cycle();
      exp_v = (m_state == 2) && (mq.size() > 0);
      checks++; if (QueueCount !== CW'(mq.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", k, QueueCount, mq.size()); end
      checks++; if (ReplayValid !== exp_v) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", k, ReplayValid, exp_v); end
      checks++; if (RunaheadActive !== (m_state != 0)) begin failures++; $display("FAIL rnd_active cyc=%0d got=%b exp=%b", k, RunaheadActive, m_state != 0); end
      checks++; if (EnqueueReady !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", k, EnqueueReady, mq.size() < DEPTH); end
      checks++; if (Overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", k, Overflow, m_ovf); end
      checks++; if (AgeTimeout !== m_to) begin failures++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", k, AgeTimeout, m_to); end
      if (exp_v) begin
        checks++; if ({ReplayAForwarded, ReplayBForwarded, ReplayInstruction} !== mq[0]) begin
          failures++; $display("FAIL rnd_head cyc=%0d got=%b%b_%h exp=%b%b_%h", k, ReplayAForwarded, ReplayBForwarded,
                               ReplayInstruction, mq[0].a, mq[0].b, mq[0].inst);
        end
      end
    end
    idle_inputs();
  endtask

`ifdef RUNAHEAD_REPLAY_AGE_LIMIT_EN
  task automatic test_age_timeout();
    int n;
    bit found;
    n = 0; found = 1'b0;
    do_reset();
    push(16'h8888, 1'b0, 1'b0);
    for (int k = 0; k < 200; k++) begin
      cycle();
      n++;
      if (AgeTimeout === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (!found || n != AGE_LIMIT) begin failures++; $display("FAIL age_pulse found=%b cycles=%0d exp=%0d", found, n, AGE_LIMIT); end
    checks++; if (ReplayValid !== 1'b1) begin failures++; $display("FAIL age_replay got=%b exp=1", ReplayValid); end
    cycle();
    checks++; if (AgeTimeout !== 1'b0) begin failures++; $display("FAIL age_one_cycle got=%b exp=0", AgeTimeout); end
  endtask
`endif

  initial begin
    idle_inputs();
    async_rst = 1'b1;
    m_state = 0; m_ovf = 1'b0; m_to = 1'b0; m_age = 0;
    test_reset();
    test_collect_hold();
    test_release_drain();
    test_overflow();
    test_replay_mid_enqueue();
    test_flush();
    test_reset_mid_replay();
`ifdef RUNAHEAD_REPLAY_AGE_LIMIT_EN
    test_age_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
